// File: rtl/lab_pkg.sv
// Shared constants for the lab board front end: switch count, debounce interval,
// and the debounce counter width helper.
package lab_pkg;

   localparam int unsigned SW_WIDTH               = 8;
   localparam int unsigned DEBOUNCE_CYCLES_100MHZ = 1_000_000;

   // Width needed to count 0..cycles-1. Floors at 1 so tiny values still get a real counter.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: two-flop synchroniser, stability counter, clean level and edge strobes.
module sw_debounce_bit
   import lab_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic sw_clean,
   output logic sw_rise,
   output logic sw_fall
);

   localparam int unsigned   CntW   = cnt_width(STABLE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

   logic            s1_q, s2_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            clean_q, clean_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   always_comb begin
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (s2_q == clean_q) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         clean_d = s2_q;
         cnt_d   = '0;
         rise_d  = s2_q;
         fall_d  = ~s2_q;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         cnt_q   <= '0;
         clean_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         s1_q    <= sw;
         s2_q    <= s1_q;
         cnt_q   <= cnt_d;
         clean_q <= clean_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign sw_clean = clean_q;
   assign sw_rise  = rise_q;
   assign sw_fall  = fall_q;

endmodule

// File: rtl/sw_debounce.sv
// Debounces the raw slide-switch vector into a clean level plus per-bit rise/fall strobes.
module sw_debounce
   import lab_pkg::*;
#(
   parameter int unsigned WIDTH         = SW_WIDTH,
   parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_100MHZ
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
         .clk     (clk),
         .rst     (rst),
         .sw      (sw[g]),
         .sw_clean(sw_clean[g]),
         .sw_rise (sw_rise[g]),
         .sw_fall (sw_fall[g])
      );
   end

endmodule
